// File: rtl/microsequencer.sv
// Microprogram sequencer: writable control store, next-address selection,
// registered microword/micro-PC and a bounded return stack with a sticky error flag.
module microsequencer #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 34,
   parameter int CR_W   = 6,
   parameter int STK_D  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [ADDR_W-1:0] dec_addr,
   input  logic [3:0]        cond,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [WORD_W-1:0] prog_data,
   output logic [WORD_W-1:0] uword,
   output logic [ADDR_W-1:0] upc,
   output logic              stk_err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(STK_D + 1);
   localparam int IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

   typedef enum logic [2:0] {
      N_DEC   = 3'd0,
      N_INC   = 3'd1,
      N_JMP   = 3'd2,
      N_BR    = 3'd3,
      N_BRDEC = 3'd4,
      N_CALL  = 3'd5,
      N_RET   = 3'd6,
      N_HOLD  = 3'd7
   } nsel_e;

   // Control store is not touched by reset; it powers up cleared.
   logic [WORD_W-1:0] store [DEPTH] = '{default: '0};
   logic [ADDR_W-1:0] stack [STK_D];
   logic [CNT_W-1:0]  count;

   nsel_e             n;
   logic              inv;
   logic [1:0]        s;
   logic              c;
   logic [ADDR_W-1:0] cr;
   logic [ADDR_W-1:0] upc_inc;
   logic [ADDR_W-1:0] nxt;
   logic              push;
   logic              pop;
   logic              err_set;
   logic              stk_full;
   logic              stk_empty;
   logic [IDX_W-1:0]  top_idx;
   logic [IDX_W-1:0]  push_idx;

   assign n         = nsel_e'(uword[WORD_W-1 -: 3]);
   assign inv       = uword[WORD_W-4];
   assign s         = uword[WORD_W-5 -: 2];
   assign cr        = ADDR_W'(uword[CR_W-1:0]);
   assign c         = cond[s] ^ inv;
   assign upc_inc   = upc + ADDR_W'(1);
   assign stk_full  = (count == CNT_W'(STK_D));
   assign stk_empty = (count == '0);
   assign top_idx   = IDX_W'(count - CNT_W'(1));
   assign push_idx  = IDX_W'(count);

   always_comb begin
      nxt     = upc_inc;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      unique case (n)
         N_DEC:   nxt = dec_addr;
         N_INC:   nxt = upc_inc;
         N_JMP:   nxt = cr;
         N_BR:    nxt = c ? cr : upc_inc;
         N_BRDEC: nxt = c ? cr : dec_addr;
         N_CALL: begin
            // A full stack still takes the jump; only the push is lost.
            nxt = cr;
            if (stk_full) err_set = 1'b1;
            else          push    = 1'b1;
         end
         N_RET: begin
            if (stk_empty) begin
               nxt     = '0;
               err_set = 1'b1;
            end else begin
               nxt = stack[top_idx];
               pop = 1'b1;
            end
         end
         N_HOLD:  nxt = c ? upc : upc_inc;
         default: nxt = upc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (prog_we) store[prog_addr] <= prog_data;
   end

   // Entries above count are don't-care, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (en && push) stack[push_idx] <= upc_inc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upc     <= '0;
         uword   <= '0;
         count   <= '0;
         stk_err <= 1'b0;
      end else if (en) begin
         upc   <= nxt;
         uword <= (prog_we && (prog_addr == nxt)) ? prog_data : store[nxt];
         if (push)    count   <= count + CNT_W'(1);
         if (pop)     count   <= count - CNT_W'(1);
         if (err_set) stk_err <= 1'b1;
      end
   end

endmodule
